// File: rtl/cf_ceil_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : cf_ceil_div_seq
// Brief    : Radix-2 restoring divider returning ceil(dividend/divisor),
//            the floor remainder and a divide-by-zero flag, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module cf_ceil_div_seq #(
    parameter int Width    = 32,
    parameter int CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CntWidth-1:0]  r_cnt;
    logic [Width-1:0]     r_dvd;
    logic [Width-1:0]     r_dvs;
    logic [Width-1:0]     r_rem;
    logic [Width-1:0]     r_quotient;
    logic [Width-1:0]     r_remainder;
    logic                 r_div_zero;

    logic [Width:0]       w_shift;
    logic                 w_qbit;
    logic [Width-1:0]     w_rem_nxt;
    logic [Width-1:0]     w_quo_nxt;
    logic [Width-1:0]     w_ceil;

    // Quotient bits are shifted into the dividend register as its bits are consumed.
    always_comb begin
        w_shift   = {r_rem, r_dvd[Width-1]};
        w_qbit    = (w_shift >= {1'b0, r_dvs});
        w_rem_nxt = w_qbit ? (w_shift[Width-1:0] - r_dvs) : w_shift[Width-1:0];
        w_quo_nxt = {r_dvd[Width-2:0], w_qbit};
        w_ceil    = w_quo_nxt + Width'(w_rem_nxt != '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_state_nxt = (divisor_i == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_dvd <= dividend_i;
                        r_dvs <= divisor_i;
                        r_rem <= '0;
                        r_cnt <= CntWidth'(Width - 1);
                        if (divisor_i == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend_i;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quotient  <= w_ceil;
                        r_remainder <= w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_div_zero;

endmodule
`default_nettype wire
